answer_checker: RTL
===================

Name: answer_checker

Overview:
- Game-round controller that sits directly upstream of the score counter.
- Synchronises the player's start and submit keys, draws pseudo-random targets from an LFSR, and compares the switch guess against the current target on each submit.
- Emits a single-cycle `answer` pulse per correct guess, which is exactly what the score counter's per-cycle increment requires.
- Runs the game countdown and drives `GameOver`, which freezes the score counter.

Parameters:
- CLK_HZ, 50_000_000: clock frequency; one game-second = CLK_HZ cycles.
- GAME_SECONDS, 60: game length in seconds; legal range 1..99 (two-digit display).
- TARGET_W, 4: width of target and guess.
- LOCKOUT_CYCLES, 1_000_000: after an accepted key press, further presses of that key are ignored for this many cycles.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- start_n  in  1  raw start key, active-low, asynchronous to clk
- submit_n  in  1  raw submit key, active-low, asynchronous to clk
- guess  in  TARGET_W  player switches; sampled only on an accepted submit
- target  out  TARGET_W  current target, shown to the player
- answer  out  1  one-cycle pulse on a correct submit
- wrong  out  1  one-cycle pulse on an incorrect submit
- GameOver  out  1  high whenever no game is running
- time_left  out  7  seconds remaining, 0..99

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, GameOver=1, answer=0, wrong=0, time_left=0, target=0.
  - LFSR=16'hACE1; prescaler=0; key synchronisers cleared to released (1); lockout counters=0.
- Key path (per key):
  - 2-flop synchroniser, then a falling-edge detector.
  - A press is accepted only if that key's lockout counter is 0; acceptance loads the counter with LOCKOUT_CYCLES-1, and it then counts down once per cycle to 0.
  - Accepted press = one-cycle internal pulse.
  - Latency: submit_n first sampled low at edge k gives `answer`/`wrong` high for the single cycle following edge k+2.
- LFSR:
  - 16-bit Galois, mask 16'hB400, shifts every cycle in all states.
  - Candidate target = lfsr[TARGET_W-1:0].
- FSM states: IDLE, PLAY, OVER.
  - IDLE: GameOver=1; submit presses ignored. Start press -> PLAY.
  - Entering PLAY: time_left=GAME_SECONDS, prescaler=0, target=candidate, GameOver=0 (all registered on the transition edge).
  - PLAY, timing:
    - Prescaler counts 0..CLK_HZ-1 and wraps.
    - On wrap, time_left decrements.
    - On the wrap with time_left==1: time_left=0, state -> OVER, GameOver=1.
  - PLAY, submit press, evaluated at the press cycle:
    - guess==target: answer=1 next cycle; target reloads from candidate. If candidate equals the current target, load candidate with bit0 inverted, so consecutive targets always differ.
    - Otherwise: wrong=1 next cycle; target unchanged.
  - PLAY, start press: ignored (no restart mid-game).
  - OVER: GameOver=1; time_left holds 0; target holds; submit presses ignored. Start press -> PLAY (new game). The score is not cleared here; only rst clears it.
- Simultaneous events:
  - Submit press on the same cycle as the final expiry wrap: expiry wins; answer=0, wrong=0; state -> OVER.
  - answer and wrong are never high together.
  - No pulse of either is ever produced while GameOver=1.
- Reset mid-game: immediate return to the reset values above; any pulse in flight is dropped.
- Widths:
  - time_left is 7-bit unsigned and never underflows.
  - The prescaler is sized to $clog2(CLK_HZ).
  - Each lockout counter is sized to $clog2(LOCKOUT_CYCLES+1).

Decomposition:
- game_pkg holds:
  - the state enum game_state_t {IDLE, PLAY, OVER};
  - LFSR_SEED=16'hACE1 and LFSR_MASK=16'hB400;
  - MAX_SECONDS=99.
- Sub-module key_sync_edge (params LOCKOUT_CYCLES; ports clk, rst, key_n, press) holds the synchroniser, edge detector and lockout counter. It is instantiated twice, once for start_n and once for submit_n.

Test Plan:
All scenarios use CLK_HZ=10, GAME_SECONDS=3, LOCKOUT_CYCLES=4, TARGET_W=4.
- Reset then idle 50 cycles: GameOver=1, time_left=0, target=0, answer=0. A submit press while in IDLE -> no answer/wrong pulse.
- Start press -> one cycle later GameOver=0, time_left=3. Then time_left=2 after 10 cycles, 1 after 20, 0 after 30, with GameOver=1 on that same edge.
- In PLAY, drive guess=target and press submit -> answer high for exactly 1 cycle, 3 cycles after the first low sample. New target != old target. Holding submit_n low for 20 cycles yields only one pulse.
- guess=target^4'h1, press submit -> wrong high for 1 cycle, answer=0, target unchanged. Two presses 2 cycles apart -> only the first is accepted (lockout).
- Submit press timed so its press pulse coincides with the final expiry wrap -> no answer/wrong pulse, GameOver=1. A later start press from OVER -> PLAY with time_left=3.
- Assert rst low mid-PLAY, asynchronously between edges -> GameOver=1 and time_left=0 immediately, without waiting for an edge. Release rst -> IDLE, and the LFSR-derived target sequence restarts identically to the post-reset run.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the guessing-game round controller.
// Holds the FSM state type, LFSR seed/mask and the two-digit display limit.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } game_state_t;

  localparam logic [15:0] LFSR_SEED   = 16'hACE1;
  localparam logic [15:0] LFSR_MASK   = 16'hB400;
  localparam int unsigned MAX_SECONDS = 99;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    lfsr_next = {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/key_sync_edge.sv
// Raw push-key front end: 2-flop synchroniser, falling-edge detector and
// a lockout counter that swallows further presses for LOCKOUT_CYCLES cycles.
module key_sync_edge #(
  parameter int unsigned LOCKOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int unsigned LW = (LOCKOUT_CYCLES == 0) ? 1 : $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [LW-1:0] RELOAD = (LOCKOUT_CYCLES == 0) ? '0 : LW'(LOCKOUT_CYCLES - 1);

  logic          sync_a;
  logic          sync_b;
  logic          key_prev;
  logic          fall;
  logic [LW-1:0] lock;

  // Idle level of an active-low key is 1, so every stage resets to released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_a   <= 1'b1;
      sync_b   <= 1'b1;
      key_prev <= 1'b1;
    end else begin
      sync_a   <= key_n;
      sync_b   <= sync_a;
      key_prev <= sync_b;
    end
  end

  assign fall  = key_prev & ~sync_b;
  assign press = fall && (lock == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock <= '0;
    end else if (press) begin
      lock <= RELOAD;
    end else if (lock != '0) begin
      lock <= lock - LW'(1);
    end
  end

endmodule

// File: rtl/answer_checker.sv
// Game-round controller: draws targets from an LFSR, grades submitted
// guesses into single-cycle answer/wrong pulses and runs the game countdown.
module answer_checker
  import game_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned GAME_SECONDS   = 60,
  parameter int unsigned TARGET_W       = 4,
  parameter int unsigned LOCKOUT_CYCLES = 1_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_n,
  input  logic                submit_n,
  input  logic [TARGET_W-1:0] guess,
  output logic [TARGET_W-1:0] target,
  output logic                answer,
  output logic                wrong,
  output logic                GameOver,
  output logic [6:0]          time_left
);

  localparam int unsigned PW = (CLK_HZ <= 1) ? 1 : $clog2(CLK_HZ);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [6:0] GAME_LOAD =
    7'((GAME_SECONDS > MAX_SECONDS) ? MAX_SECONDS : GAME_SECONDS);

  game_state_t         state;
  logic [15:0]         lfsr;
  logic [PW-1:0]       presc;
  logic                start_press;
  logic                submit_press;
  logic                wrap;
  logic                final_wrap;
  logic [TARGET_W-1:0] candidate;
  logic [TARGET_W-1:0] next_target;

  key_sync_edge #(.LOCKOUT_CYCLES(LOCKOUT_CYCLES)) u_start_key (
    .clk   (clk),
    .rst   (rst),
    .key_n (start_n),
    .press (start_press)
  );

  key_sync_edge #(.LOCKOUT_CYCLES(LOCKOUT_CYCLES)) u_submit_key (
    .clk   (clk),
    .rst   (rst),
    .key_n (submit_n),
    .press (submit_press)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  assign candidate  = lfsr[TARGET_W-1:0];
  assign wrap       = (presc == PRESC_LAST);
  assign final_wrap = wrap && (time_left <= 7'd1);

  // Consecutive targets must differ, so a repeated draw gets bit 0 flipped.
  always_comb begin
    next_target = candidate;
    if (candidate == target) begin
      next_target = candidate ^ TARGET_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      time_left <= '0;
      presc     <= '0;
      target    <= '0;
      answer    <= 1'b0;
      wrong     <= 1'b0;
    end else begin
      answer <= 1'b0;
      wrong  <= 1'b0;
      unique case (state)
        IDLE, OVER: begin
          if (start_press) begin
            state     <= PLAY;
            time_left <= GAME_LOAD;
            presc     <= '0;
            target    <= candidate;
          end
        end
        PLAY: begin
          if (wrap) begin
            presc <= '0;
            if (time_left <= 7'd1) begin
              time_left <= '0;
              state     <= OVER;
            end else begin
              time_left <= time_left - 7'd1;
            end
          end else begin
            presc <= presc + PW'(1);
          end
          // Expiry on the same cycle as a submit suppresses the grade.
          if (submit_press && !final_wrap) begin
            if (guess == target) begin
              answer <= 1'b1;
              target <= next_target;
            end else begin
              wrong <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign GameOver = (state != PLAY);

endmodule
